// File: rtl/keypad_calc_if.sv
// Keyboard-to-calculator bus: key events in, display value/status out.
interface keypad_calc_if #(
  parameter int unsigned NUM_W = 10
);
  logic             key_valid;
  logic [4:0]       key_code;
  logic [NUM_W-1:0] value;
  logic             neg;
  logic             err;
  logic [1:0]       state;
  logic             key_ack;

  modport master (
    output key_valid, key_code,
    input  value, neg, err, state, key_ack
  );

  modport slave (
    input  key_valid, key_code,
    output value, neg, err, state, key_ack
  );
endinterface

// File: rtl/keypad_calc_core.sv
// Keypad calculator core: DIGITS-digit operand entry, add/subtract, clear, overflow.
// Optional macro CALC_CHAIN_EN lets an operator in RESULT chain the result into A.
module keypad_calc_core #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned NUM_W  = 10
) (
  input logic          clk_in,
  input logic          rst,
  keypad_calc_if.slave bus
);
  localparam int unsigned MAX_VAL = 10**DIGITS - 1;
  localparam int unsigned CNT_W   = $clog2(DIGITS + 1);
  localparam int unsigned R_W     = NUM_W + 2;

  if (!((64'd1 << NUM_W) > 64'(MAX_VAL))) begin : g_width_chk
    $error("keypad_calc_core: NUM_W too small to hold MAX_VAL");
  end

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    RESULT  = 2'd2,
    ERROR   = 2'd3
  } state_t;

  state_t                  st, st_n;
  logic [NUM_W-1:0]        cur, cur_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic signed [NUM_W:0]   a_q, a_n;
  logic                    op_sub, op_sub_n;
  logic [NUM_W-1:0]        value_q, value_n;
  logic                    neg_q, neg_n;
  logic                    err_q, err_n;
  logic                    ack_q, ack_n;

  logic sync1, sync2, sync3;
  logic key_evt_c;

  logic       is_digit, is_op, op_is_sub, is_eq, is_clr;
  logic [3:0] digit;
  logic [NUM_W-1:0]      cur_shift;
  logic signed [R_W-1:0] a_ext, b_ext, r;
  logic [R_W-1:0]        r_abs;
  logic                  ovf;

  // Asynchronous key level into clk_in, then rising-edge detect
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.key_valid;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end
  assign key_evt_c = sync2 & ~sync3;

  // Key index to function decode
  always_comb begin
    is_digit  = 1'b1;
    digit     = 4'd0;
    is_op     = 1'b0;
    op_is_sub = 1'b0;
    is_eq     = 1'b0;
    is_clr    = 1'b0;
    case (bus.key_code)
      5'd0:    digit = 4'd1;
      5'd1:    digit = 4'd2;
      5'd2:    digit = 4'd3;
      5'd4:    digit = 4'd4;
      5'd5:    digit = 4'd5;
      5'd6:    digit = 4'd6;
      5'd8:    digit = 4'd7;
      5'd9:    digit = 4'd8;
      5'd10:   digit = 4'd9;
      5'd13:   digit = 4'd0;
      default: is_digit = 1'b0;
    endcase
    case (bus.key_code)
      5'd3:    is_op = 1'b1;
      5'd11: begin
        is_op     = 1'b1;
        op_is_sub = 1'b1;
      end
      5'd7:    is_eq  = 1'b1;
      5'd12:   is_clr = 1'b1;
      default: ;
    endcase
  end

  // Datapath: decimal shift-in and signed A op B with magnitude/overflow
  always_comb begin
    cur_shift = (cur << 3) + (cur << 1) + NUM_W'(digit);
    a_ext     = {a_q[NUM_W], a_q};
    b_ext     = {2'b00, cur};
    r         = op_sub ? (a_ext - b_ext) : (a_ext + b_ext);
    r_abs     = r[R_W-1] ? -r : r;
    ovf       = r_abs > R_W'(MAX_VAL);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      st      <= ENTER_A;
      cur     <= '0;
      cnt     <= '0;
      a_q     <= '0;
      op_sub  <= 1'b0;
      value_q <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      st      <= st_n;
      cur     <= cur_n;
      cnt     <= cnt_n;
      a_q     <= a_n;
      op_sub  <= op_sub_n;
      value_q <= value_n;
      neg_q   <= neg_n;
      err_q   <= err_n;
      ack_q   <= ack_n;
    end
  end

  always_comb begin
    st_n     = st;
    cur_n    = cur;
    cnt_n    = cnt;
    a_n      = a_q;
    op_sub_n = op_sub;
    value_n  = value_q;
    neg_n    = neg_q;
    err_n    = err_q;
    ack_n    = 1'b0;
    if (key_evt_c) begin
      if (is_clr) begin
        st_n     = ENTER_A;
        cur_n    = '0;
        cnt_n    = '0;
        a_n      = '0;
        op_sub_n = 1'b0;
        value_n  = '0;
        neg_n    = 1'b0;
        err_n    = 1'b0;
        ack_n    = 1'b1;
      end else begin
        case (st)
          ENTER_A, ENTER_B: begin
            if (is_digit) begin
              ack_n = 1'b1;
              // A full operand swallows further digits but still acknowledges them
              if (cnt != CNT_W'(DIGITS)) begin
                cur_n   = cur_shift;
                value_n = cur_shift;
                if (cur != '0 || digit != 4'd0) cnt_n = cnt + CNT_W'(1);
              end
            end else if (is_op) begin
              ack_n    = 1'b1;
              op_sub_n = op_is_sub;
              if (st == ENTER_A) begin
                a_n     = $signed({1'b0, cur});
                cur_n   = '0;
                cnt_n   = '0;
                value_n = '0;
                st_n    = ENTER_B;
              end
            end else if (is_eq && st == ENTER_B) begin
              ack_n = 1'b1;
              cur_n = '0;
              cnt_n = '0;
              if (ovf) begin
                st_n    = ERROR;
                err_n   = 1'b1;
                value_n = '0;
                neg_n   = 1'b0;
              end else begin
                st_n    = RESULT;
                value_n = NUM_W'(r_abs);
                neg_n   = r[R_W-1];
              end
            end
          end
          RESULT: begin
            if (is_digit) begin
              ack_n   = 1'b1;
              st_n    = ENTER_A;
              cur_n   = NUM_W'(digit);
              cnt_n   = CNT_W'(digit != 4'd0);
              value_n = NUM_W'(digit);
              neg_n   = 1'b0;
            end
`ifdef CALC_CHAIN_EN
            else if (is_op) begin
              ack_n    = 1'b1;
              a_n      = neg_q ? -$signed({1'b0, value_q}) : $signed({1'b0, value_q});
              op_sub_n = op_is_sub;
              cur_n    = '0;
              cnt_n    = '0;
              value_n  = '0;
              neg_n    = 1'b0;
              st_n     = ENTER_B;
            end
`else
            else begin
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.value   = value_q;
  assign bus.neg     = neg_q;
  assign bus.err     = err_q;
  assign bus.state   = st;
  assign bus.key_ack = ack_q;
endmodule

// File: tb/tb_keypad_calc_core.sv
// Directed bench for keypad_calc_core: entry, arithmetic, overflow, sync latency, async reset.
module tb_keypad_calc_core;
  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ack_cnt  = 0;
  int   ack_base;

  keypad_calc_if #(.NUM_W(10)) bus ();

  keypad_calc_core #(.DIGITS(3), .NUM_W(10)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (bus.key_ack) ack_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic press(input logic [4:0] c);
    @(negedge clk_in);
    bus.key_code  = c;
    bus.key_valid = 1'b1;
    repeat (4) @(negedge clk_in);
    bus.key_valid = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic press_seq(input logic [4:0] seq[$]);
    foreach (seq[i]) press(seq[i]);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    repeat (3) @(negedge clk_in);
    check("rst_value", int'(bus.value), 0);
    check("rst_neg",   int'(bus.neg),   0);
    check("rst_err",   int'(bus.err),   0);
    check("rst_state", int'(bus.state), 0);
    check("rst_ack",   int'(bus.key_ack), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    // 123 + 45 = 168
    ack_base = ack_cnt;
    press_seq('{5'd0, 5'd1, 5'd2});
    check("a_entry", int'(bus.value), 123);
    press(5'd3);
    check("op_value", int'(bus.value), 0);
    check("op_state", int'(bus.state), 1);
    press_seq('{5'd4, 5'd5});
    check("b_entry", int'(bus.value), 45);
    press(5'd7);
    check("add_value", int'(bus.value), 168);
    check("add_neg",   int'(bus.neg),   0);
    check("add_state", int'(bus.state), 2);
    check("add_acks",  ack_cnt - ack_base, 7);

    // Digit in RESULT starts fresh entry; 5 - 9 = -4
    press(5'd5);
    check("fresh_value", int'(bus.value), 5);
    check("fresh_state", int'(bus.state), 0);
    press_seq('{5'd11, 5'd10, 5'd7});
    check("sub_value", int'(bus.value), 4);
    check("sub_neg",   int'(bus.neg),   1);
    check("sub_state", int'(bus.state), 2);

    // Digit limit, overflow, error lockout, clear
    press(5'd12);
    check("clr_state", int'(bus.state), 0);
    check("clr_neg",   int'(bus.neg),   0);
    ack_base = ack_cnt;
    press_seq('{5'd10, 5'd10, 5'd10, 5'd10});
    check("full_value", int'(bus.value), 999);
    check("full_acks",  ack_cnt - ack_base, 4);
    press_seq('{5'd3, 5'd0, 5'd7});
    check("ovf_state", int'(bus.state), 3);
    check("ovf_err",   int'(bus.err),   1);
    check("ovf_value", int'(bus.value), 0);
    ack_base = ack_cnt;
    press(5'd3);
    check("err_noack", ack_cnt - ack_base, 0);
    check("err_hold",  int'(bus.state), 3);
    press(5'd12);
    check("err_clr_state", int'(bus.state), 0);
    check("err_clr_err",   int'(bus.err),   0);
    check("err_clr_ack",   ack_cnt - ack_base, 1);

    // Leading zeros are free; fourth significant digit dropped; codes 14/15 ignored
    press_seq('{5'd13, 5'd13, 5'd0, 5'd1, 5'd2, 5'd4});
    check("lead_zero", int'(bus.value), 123);
    ack_base = ack_cnt;
    press_seq('{5'd14, 5'd15});
    check("ign_acks",  ack_cnt - ack_base, 0);
    check("ign_value", int'(bus.value), 123);

    // Sync latency and no auto-repeat while held
    press(5'd12);
    ack_base = ack_cnt;
    @(negedge clk_in);
    bus.key_code  = 5'd0;
    bus.key_valid = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    check("lat_edge2_value", int'(bus.value), 0);
    @(posedge clk_in); #1;
    check("lat_edge3_value", int'(bus.value), 1);
    check("lat_edge3_ack",   int'(bus.key_ack), 1);
    repeat (197) @(negedge clk_in);
    bus.key_valid = 1'b0;
    repeat (5) @(negedge clk_in);
    check("hold_acks", ack_cnt - ack_base, 1);

    // Async reset mid-ENTER_B, away from any clock edge
    press(5'd12);
    press_seq('{5'd0, 5'd1, 5'd3, 5'd2});
    check("preRst_value", int'(bus.value), 3);
    check("preRst_state", int'(bus.state), 1);
    @(negedge clk_in);
    #1 rst = 1'b1;
    #1;
    check("arst_value", int'(bus.value), 0);
    check("arst_state", int'(bus.state), 0);
    check("arst_neg",   int'(bus.neg),   0);
    check("arst_err",   int'(bus.err),   0);
    @(negedge clk_in);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    // Result chaining: 2 - 5 = -3, then operator in RESULT
    press_seq('{5'd1, 5'd11, 5'd5, 5'd7});
    check("chain_r_value", int'(bus.value), 3);
    check("chain_r_neg",   int'(bus.neg),   1);
    ack_base = ack_cnt;
    press(5'd3);
`ifdef CALC_CHAIN_EN
    check("chain_op_ack",   ack_cnt - ack_base, 1);
    check("chain_op_state", int'(bus.state), 1);
    press_seq('{5'd8, 5'd7});
    check("chain_value", int'(bus.value), 4);
    check("chain_neg",   int'(bus.neg),   0);
    check("chain_state", int'(bus.state), 2);
`else
    check("chain_op_ack",   ack_cnt - ack_base, 0);
    check("chain_op_state", int'(bus.state), 2);
    press(5'd8);
    check("chain_value", int'(bus.value), 7);
    check("chain_neg",   int'(bus.neg),   0);
    check("chain_state", int'(bus.state), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
